// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection light controller.
//   light_state_t : controller states (six-phase cycle plus NIGHT)
//   SEG_BLANK     : common-anode pattern with every segment off
//   seg7_decode   : BCD digit -> {dp,g,f,e,d,c,b,a}, active-low, dp off
//   pow10         : 10**n for elaboration checks and BCD extraction
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G,
        NS_Y,
        AR1,
        EW_G,
        EW_Y,
        AR2,
        NIGHT
    } light_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg7_decode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   bcd        : DIGITS packed BCD nibbles, nibble 0 = ones digit
//   blank      : per-digit blank mask, 1 = show SEG_BLANK
//   seg_out    : {dp,g,f,e,d,c,b,a} of the selected digit, 0 = segment on
//   seg_sel    : one-hot-low digit select, bit 0 = ones digit
// Each digit is held for SCAN_DIV clocks; the scan starts on the ones digit.
module seg7_scan
    import traffic_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 2**16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS*4-1:0]   bcd,
    input  logic [DIGITS-1:0]     blank,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     seg_sel
);

    localparam int SCAN_LEN = SCAN_DIV * DIGITS;
    localparam int SW       = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;

    logic [SW-1:0] scan_cnt;
    int unsigned   digit_idx;
    logic [3:0]    digit_sel;
    logic          blank_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
        end else if (scan_cnt == SW'(SCAN_LEN - 1)) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Division is done at 32 bits so a SCAN_DIV that does not fit in SW
    // (single-digit builds) cannot collapse to a zero divisor.
    always_comb begin
        digit_idx = 32'(scan_cnt) / 32'(SCAN_DIV);
        digit_sel = 4'd0;
        blank_sel = 1'b0;
        seg_sel   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == 32'(i)) begin
                seg_sel[i] = 1'b0;
                digit_sel  = bcd[i*4 +: 4];
                blank_sel  = blank[i];
            end
        end
        seg_out = blank_sel ? SEG_BLANK : seg7_decode(digit_sel);
    end

endmodule

// File: rtl/intersection_light_ctrl.sv
// Two-road (NS/EW) traffic-light controller with all-red clearance,
// pedestrian green shortening, flashing-yellow night mode and a
// multiplexed countdown display.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   ped_req : pedestrian button (pulse or level, synchronous to clk)
//   night   : night-mode request (level)
//   led_ns  : {r,y,g} for the NS road, 1 = lit
//   led_ew  : {r,y,g} for the EW road, 1 = lit
//   seg_out : {dp,g,f,e,d,c,b,a}, 0 = segment on, dp always off
//   seg_sel : one-hot-low digit select, bit 0 = ones digit
module intersection_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int GREEN_TIME    = 30,
    parameter int YELLOW_TIME   = 5,
    parameter int ALL_RED_TIME  = 2,
    parameter int PED_MIN_GREEN = 5,
    parameter int YELLOW_BLINK  = 1,
    parameter int DIGITS        = 2,
    parameter int SCAN_DIV      = 2**16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ped_req,
    input  logic              night,
    output logic [2:0]        led_ns,
    output logic [2:0]        led_ew,
    output logic [7:0]        seg_out,
    output logic [DIGITS-1:0] seg_sel
);

    localparam int MAX_GY = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
    localparam int MAX_T  = (MAX_GY > ALL_RED_TIME) ? MAX_GY : ALL_RED_TIME;
    localparam int CNT_W  = $clog2(MAX_T + 1);
    localparam int PW     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALL_RED_TIME);
    localparam logic [CNT_W-1:0] PED_C    = CNT_W'(PED_MIN_GREEN);

    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("intersection_light_ctrl: DIGITS must be 1..4");
    end
    if (MAX_T > pow10(DIGITS) - 1) begin : g_bad_range
        $error("intersection_light_ctrl: longest phase does not fit the display");
    end
    if (PED_MIN_GREEN > GREEN_TIME) begin : g_bad_ped
        $error("intersection_light_ctrl: PED_MIN_GREEN exceeds GREEN_TIME");
    end

    logic [PW-1:0]       presc;
    logic                sec_tick;
    logic                half_tick;
    logic                blink_on;
    logic                yellow_lvl;

    light_state_t        state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                ped_pend, ped_next;
    logic                last_sec;

    logic [DIGITS*4-1:0] bcd;
    logic [DIGITS-1:0]   blank;

    assign sec_tick   = (presc == PW'(CLK_FREQ - 1));
    assign half_tick  = sec_tick || (presc == PW'(CLK_FREQ / 2 - 1));
    assign yellow_lvl = (YELLOW_BLINK != 0) ? blink_on : 1'b1;
    assign last_sec   = sec_tick && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            blink_on <= 1'b1;
        end else begin
            presc <= sec_tick ? '0 : presc + 1'b1;
            if (half_tick) begin
                blink_on <= ~blink_on;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NS_G;
            cnt      <= GREEN_C;
            ped_pend <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ped_pend <= ped_next;
        end
    end

    // The pedestrian shortening is applied after the countdown so that it
    // wins over a same-cycle decrement; it can never coincide with the last
    // second because it only fires while cnt > PED_MIN_GREEN >= 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ped_next   = ped_pend | ped_req;
        led_ns     = 3'b100;
        led_ew     = 3'b100;

        if (sec_tick && !last_sec && state != NIGHT) begin
            cnt_next = cnt - 1'b1;
        end

        case (state)
            NS_G: begin
                led_ns = 3'b001;
                if (last_sec) begin
                    state_next = NS_Y;
                    cnt_next   = YELLOW_C;
                end else if (ped_pend && cnt > PED_C) begin
                    cnt_next = PED_C;
                end
            end
            NS_Y: begin
                led_ns = {1'b0, yellow_lvl, 1'b0};
                if (last_sec) begin
                    state_next = AR1;
                    cnt_next   = ALLRED_C;
                end
            end
            AR1: begin
                if (last_sec) begin
                    state_next = night ? NIGHT : EW_G;
                    cnt_next   = GREEN_C;
                end
            end
            EW_G: begin
                led_ew = 3'b001;
                if (last_sec) begin
                    state_next = EW_Y;
                    cnt_next   = YELLOW_C;
                end else if (ped_pend && cnt > PED_C) begin
                    cnt_next = PED_C;
                end
            end
            EW_Y: begin
                led_ew = {1'b0, yellow_lvl, 1'b0};
                if (last_sec) begin
                    state_next = AR2;
                    cnt_next   = ALLRED_C;
                end
            end
            AR2: begin
                if (last_sec) begin
                    state_next = night ? NIGHT : NS_G;
                    cnt_next   = GREEN_C;
                end
            end
            NIGHT: begin
                led_ns = {1'b0, blink_on, 1'b0};
                led_ew = {1'b0, blink_on, 1'b0};
                if (sec_tick && !night) begin
                    state_next = AR2;
                    cnt_next   = ALLRED_C;
                end
            end
            default: begin
                state_next = NS_G;
                cnt_next   = GREEN_C;
            end
        endcase

        // A pending request is consumed by the yellow it caused (or would
        // have met) and is never carried through night mode.
        if ((state_next != state && (state_next == NS_Y || state_next == EW_Y))
            || state_next == NIGHT || state == NIGHT) begin
            ped_next = 1'b0;
        end
    end

    // Leading zeros are blanked above the ones digit; night blanks everything.
    always_comb begin
        bcd   = '0;
        blank = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd[i*4 +: 4] = 4'((32'(cnt) / pow10(i)) % 10);
            if ((i > 0 && 32'(cnt) < pow10(i)) || state == NIGHT) begin
                blank[i] = 1'b1;
            end
        end
    end

    seg7_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .bcd     (bcd),
        .blank   (blank),
        .seg_out (seg_out),
        .seg_sel (seg_sel)
    );

endmodule

// File: tb/tb_intersection_light_ctrl.sv
// Directed bench for intersection_light_ctrl (CLK_FREQ=10, GREEN=5,
// YELLOW=2, ALL_RED=1, PED_MIN=2, DIGITS=2, SCAN_DIV=4) plus a second
// instance with GREEN=12 for the two-digit display. Cycle numbers count
// rising edges since reset release; outputs are sampled on falling edges.
module tb_intersection_light_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [2:0] led_ns, led_ew;
    logic [7:0] seg_out;
    logic [1:0] seg_sel;

    logic [2:0] led_ns2, led_ew2;
    logic [7:0] seg_out2;
    logic [1:0] seg_sel2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    intersection_light_ctrl #(
        .CLK_FREQ(10), .GREEN_TIME(5), .YELLOW_TIME(2), .ALL_RED_TIME(1),
        .PED_MIN_GREEN(2), .YELLOW_BLINK(1), .DIGITS(2), .SCAN_DIV(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .night(night),
        .led_ns(led_ns), .led_ew(led_ew), .seg_out(seg_out), .seg_sel(seg_sel)
    );

    intersection_light_ctrl #(
        .CLK_FREQ(10), .GREEN_TIME(12), .YELLOW_TIME(2), .ALL_RED_TIME(1),
        .PED_MIN_GREEN(2), .YELLOW_BLINK(1), .DIGITS(2), .SCAN_DIV(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .ped_req(1'b0), .night(1'b0),
        .led_ns(led_ns2), .led_ew(led_ew2), .seg_out(seg_out2), .seg_sel(seg_sel2)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)",
                   tag, observed, expected, cyc);
        end
    endtask

    task automatic advanceTo(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Drives the request inputs at the current sample point.
    task automatic applyStimulus(input logic ped, input logic nt);
        ped_req = ped;
        night   = nt;
    endtask

    task automatic pedPulse(input logic nt);
        applyStimulus(1'b1, nt);
        advanceTo(cyc + 1);
        applyStimulus(1'b0, nt);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_hold_led_ns", 8'(led_ns), 8'h01);
        checkOutput("rst_hold_led_ew", 8'(led_ew), 8'h04);
        rst_n = 1'b1;
        cyc   = 0;

        // Reset state and idle cycle timing
        checkOutput("reset_led_ns", 8'(led_ns), 8'h01);
        checkOutput("reset_led_ew", 8'(led_ew), 8'h04);
        checkOutput("reset_seg_sel", 8'(seg_sel), 8'h02);
        checkOutput("reset_seg_out", seg_out, 8'h92);
        checkOutput("g12_ones_seg_sel", 8'(seg_sel2), 8'h02);
        checkOutput("g12_ones_seg_out", seg_out2, 8'hA4);
        advanceTo(4);
        checkOutput("g12_tens_seg_sel", 8'(seg_sel2), 8'h01);
        checkOutput("g12_tens_seg_out", seg_out2, 8'hF9);
        advanceTo(8);
        checkOutput("g12_ones_again", seg_out2, 8'hA4);
        advanceTo(49);
        checkOutput("ns_g_last", 8'(led_ns), 8'h01);
        advanceTo(50);
        checkOutput("ns_y_on_ns", 8'(led_ns), 8'h02);
        checkOutput("ns_y_on_ew", 8'(led_ew), 8'h04);
        advanceTo(55);
        checkOutput("ns_y_off_ns", 8'(led_ns), 8'h00);
        advanceTo(70);
        checkOutput("ar1_ns", 8'(led_ns), 8'h04);
        checkOutput("ar1_ew", 8'(led_ew), 8'h04);
        advanceTo(72);
        checkOutput("g12_cnt5_ones", seg_out2, 8'h92);
        advanceTo(76);
        checkOutput("g12_cnt5_tens_sel", 8'(seg_sel2), 8'h01);
        checkOutput("g12_cnt5_tens_blank", seg_out2, 8'hFF);
        advanceTo(80);
        checkOutput("ew_g_ns", 8'(led_ns), 8'h04);
        checkOutput("ew_g_ew", 8'(led_ew), 8'h01);
        advanceTo(130);
        checkOutput("ew_y_ew", 8'(led_ew), 8'h02);
        advanceTo(150);
        checkOutput("ar2_ns", 8'(led_ns), 8'h04);
        checkOutput("ar2_ew", 8'(led_ew), 8'h04);
        advanceTo(160);
        checkOutput("period_ns_g", 8'(led_ns), 8'h01);

        // Pedestrian request at cnt=4 shortens NS green to 2 ticks
        advanceTo(172);
        pedPulse(1'b0);
        advanceTo(176);
        checkOutput("ped_cnt2_display", seg_out, 8'hA4);
        advanceTo(189);
        checkOutput("ped_ns_g_last", 8'(led_ns), 8'h01);
        advanceTo(190);
        checkOutput("ped_ns_y_start", 8'(led_ns), 8'h02);
        checkOutput("ped_pend_clear_ns_y", 8'(dut.ped_pend), 8'h00);

        // Request at cnt=2 in EW_G has no effect
        advanceTo(252);
        pedPulse(1'b0);
        advanceTo(269);
        checkOutput("late_ped_ew_g", 8'(led_ew), 8'h01);
        advanceTo(270);
        checkOutput("late_ped_ew_y", 8'(led_ew), 8'h02);
        checkOutput("ped_pend_clear_ew_y", 8'(dut.ped_pend), 8'h00);

        // Request during AR1 shortens the following EW green
        advanceTo(372);
        pedPulse(1'b0);
        advanceTo(384);
        checkOutput("held_ped_cnt2", seg_out, 8'hA4);
        advanceTo(399);
        checkOutput("held_ped_ew_g_last", 8'(led_ew), 8'h01);
        advanceTo(400);
        checkOutput("held_ped_ew_y", 8'(led_ew), 8'h02);

        // Night mode entered after AR1, left via AR2
        advanceTo(435);
        applyStimulus(1'b0, 1'b1);
        advanceTo(509);
        checkOutput("pre_night_ns", 8'(led_ns), 8'h04);
        checkOutput("pre_night_ew", 8'(led_ew), 8'h04);
        advanceTo(510);
        checkOutput("night_on_ns", 8'(led_ns), 8'h02);
        checkOutput("night_on_ew", 8'(led_ew), 8'h02);
        advanceTo(512);
        checkOutput("night_blank_ones", seg_out, 8'hFF);
        advanceTo(515);
        checkOutput("night_off_ns", 8'(led_ns), 8'h00);
        checkOutput("night_off_ew", 8'(led_ew), 8'h00);
        pedPulse(1'b1);
        advanceTo(517);
        checkOutput("night_ped_held0", 8'(dut.ped_pend), 8'h00);
        advanceTo(520);
        checkOutput("night_stay_ew", 8'(led_ew), 8'h02);
        checkOutput("night_blank_again", seg_out, 8'hFF);
        advanceTo(523);
        applyStimulus(1'b0, 1'b0);
        advanceTo(529);
        checkOutput("night_last_ns", 8'(led_ns), 8'h00);
        advanceTo(530);
        checkOutput("exit_ar2_ns", 8'(led_ns), 8'h04);
        checkOutput("exit_ar2_ew", 8'(led_ew), 8'h04);
        advanceTo(539);
        checkOutput("exit_ar2_end", 8'(led_ns), 8'h04);
        advanceTo(540);
        checkOutput("exit_ns_g", 8'(led_ns), 8'h01);
        advanceTo(544);
        checkOutput("exit_cnt5", seg_out, 8'h92);
        advanceTo(589);
        checkOutput("full_green_after_night", 8'(led_ns), 8'h01);
        advanceTo(590);
        checkOutput("ns_y_after_night", 8'(led_ns), 8'h02);

        // Asynchronous reset in the middle of EW_Y
        advanceTo(675);
        checkOutput("mid_ew_y", 8'(led_ew), 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ns", 8'(led_ns), 8'h01);
        checkOutput("async_rst_ew", 8'(led_ew), 8'h04);
        checkOutput("async_rst_sel", 8'(seg_sel), 8'h02);
        checkOutput("async_rst_seg", seg_out, 8'h92);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        advanceTo(49);
        checkOutput("restart_ns_g_last", 8'(led_ns), 8'h01);
        advanceTo(50);
        checkOutput("restart_ns_y", 8'(led_ns), 8'h02);
        advanceTo(80);
        checkOutput("restart_ew_g", 8'(led_ew), 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
